// File: rtl/phy_rx_pkg.sv
// Shared definitions for the serial receive path: comma symbol, alignment
// state encoding and comma-counter width.
package phy_rx_pkg;

  localparam logic [7:0]  COMMA_DEFAULT = 8'hBC;
  localparam int unsigned COMMA_CNT_W   = 4;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    ACTIVE
  } rx_state_e;

endpackage

// File: rtl/sp_shift_ctr.sv
// Serial shift register with a 3-bit bit counter; realign forces the next
// byte boundary to land exactly eight edges after the realigning edge.
module sp_shift_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       realign,
  output logic [7:0] word,
  output logic [7:0] word_q,
  output logic       boundary,
  output logic       first_bit
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = {shreg_q[6:0], data_in};
    cnt_d   = realign ? 3'd0 : cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // word is the post-shift byte seen at this edge; word_q is the byte that
  // completed on the previous edge when first_bit is high.
  assign word      = shreg_d;
  assign word_q    = shreg_q;
  assign boundary  = (cnt_q == 3'd7);
  assign first_bit = (cnt_q == 3'd0);

endmodule

// File: rtl/serial_paralelo_bc_align.sv
// Receive-side serial-to-parallel converter: locks byte alignment on a run of
// boundary-aligned commas and then emits bytes held for eight bit clocks.
module serial_paralelo_bc_align
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COMMA    = COMMA_DEFAULT,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [COMMA_CNT_W-1:0] BcCountW = COMMA_CNT_W'(BC_COUNT);

  rx_state_e              state_q, state_d;
  logic [COMMA_CNT_W-1:0] ccnt_q, ccnt_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   active_q, active_d;

  logic       realign;
  logic [7:0] word, word_q;
  logic       boundary, first_bit;

  sp_shift_ctr u_shift (
    .clk       (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .realign   (realign),
    .word      (word),
    .word_q    (word_q),
    .boundary  (boundary),
    .first_bit (first_bit)
  );

  assign realign = (state_q == SEARCH) && (word == COMMA);

  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    unique case (state_q)
      SEARCH: begin
        if (realign) begin
          ccnt_d  = COMMA_CNT_W'(1);
          state_d = (BC_COUNT == 1) ? ACTIVE : CHECK;
        end
      end
      CHECK: begin
        if (boundary) begin
          if (word == COMMA) begin
            ccnt_d = ccnt_q + COMMA_CNT_W'(1);
            if (ccnt_d == BcCountW) state_d = ACTIVE;
          end else begin
            ccnt_d  = '0;
            state_d = SEARCH;
          end
        end
      end
      ACTIVE:  state_d = ACTIVE;
      default: state_d = SEARCH;
    endcase
  end

  // Outputs refresh on the edge after a boundary, so every byte is held for
  // a full eight-edge window.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    active_d = (state_q == ACTIVE);
    if (first_bit) begin
      if (state_q == ACTIVE) begin
        data_d  = word_q;
        valid_d = (word_q != COMMA);
      end else begin
        data_d  = 8'h00;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q  <= SEARCH;
      ccnt_q   <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ccnt_q   <= ccnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_bc_align.sv
// Bench for serial_paralelo_bc_align: directed and random bit streams checked
// each edge against a bit-history reference model.
module tb_serial_paralelo_bc_align;

  localparam logic [7:0] BC   = 8'hBC;
  localparam int         NBC  = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int vectors    = 0;
  int miscompares = 0;

  serial_paralelo_bc_align #(
    .COMMA    (BC),
    .BC_COUNT (NBC)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: mode 0 = hunting every edge, 1 = counting aligned
  // commas, 2 = locked. Boundaries are tracked as absolute edge times.
  int         t        = 0;
  int         mode     = 0;
  int         ncomma   = 0;
  int         next_bnd = 0;
  logic [7:0] win      = 8'h00;
  bit         pend     = 0;
  bit         pend_lock = 0;
  logic [7:0] pend_byte = 8'h00;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_active = 1'b0;

  task automatic model_step(input logic b, input logic rst);
    t++;
    if (rst) begin
      win = 8'h00; mode = 0; ncomma = 0; pend = 0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_active = 1'b0;
      return;
    end
    if (pend) begin
      if (pend_lock) begin
        exp_data   = pend_byte;
        exp_valid  = (pend_byte != BC);
        exp_active = 1'b1;
      end else begin
        exp_data  = 8'h00;
        exp_valid = 1'b0;
      end
      pend = 0;
    end
    win = {win[6:0], b};
    if (mode == 0) begin
      if (win == BC) begin
        ncomma    = 1;
        mode      = (NBC == 1) ? 2 : 1;
        next_bnd  = t + 8;
        pend      = 1;
        pend_byte = win;
        pend_lock = (mode == 2);
      end
    end else if (t == next_bnd) begin
      next_bnd  = t + 8;
      pend      = 1;
      pend_byte = win;
      if (mode == 1) begin
        if (win == BC) begin
          ncomma++;
          if (ncomma == NBC) mode = 2;
        end else begin
          mode   = 0;
          ncomma = 0;
        end
      end
      pend_lock = (mode == 2);
    end
  endtask

  task automatic check_outputs();
    vectors++;
    assert (data_out === exp_data) else begin
      miscompares++;
      $error("FAIL data_out edge=%0d got=%h exp=%h", t, data_out, exp_data);
    end
    vectors++;
    assert (valid_out === exp_valid) else begin
      miscompares++;
      $error("FAIL valid_out edge=%0d got=%b exp=%b", t, valid_out, exp_valid);
    end
    vectors++;
    assert (active === exp_active) else begin
      miscompares++;
      $error("FAIL active edge=%0d got=%b exp=%b", t, active, exp_active);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    model_step(b, reset);
    #1;
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_random_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(BC);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    send_random_bits(n);
    reset = 1'b0;
  endtask

  initial begin
    // Reset with random data on the lane.
    do_reset(3);

    // Random preamble, lock, then three payload bytes.
    send_random_bits(3);
    send_commas(4);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hFF);
    send_random_bits(8);

    // Interrupted comma run falls back to search, then a clean lock.
    do_reset(2);
    send_commas(3);
    send_byte(8'h12);
    send_commas(4);
    send_byte(8'h77);

    // Idle comma between payload bytes, then 0xBC straddling a boundary.
    send_byte(8'h55);
    send_byte(BC);
    send_byte(8'h66);
    send_byte(8'h0B);
    send_byte(8'hC0);

    // Random payload while locked, including random commas.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) send_byte(BC);
      else send_byte(8'($urandom));
    end

    // Reset mid-byte while locked, then relock on a new phase.
    send_random_bits(3);
    do_reset(1);
    send_random_bits(5);
    send_commas(3);
    send_byte(8'h5A);
    send_random_bits(2);
    send_commas(4);
    for (int i = 0; i < 12; i++) send_byte(8'($urandom));

    // Unlocked noise followed by a fresh lock.
    do_reset(2);
    send_random_bits(64);
    send_commas(4);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    send_random_bits(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
